// File: rtl/uart_tx_frame.sv
// UART transmitter: start, DATA_BITS payload (LSB first), optional parity, 1-2 stop bits.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry FIFO in front of the FSM.
module uart_tx_frame #(
  parameter int F_CLK      = 1_000_000,
  parameter int BAUDRATE   = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CLKS_PER_BIT = F_CLK / BAUDRATE;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic ODD = (PARITY == 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_tx_frame: PARITY must be 0..2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1..2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]        div;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par;
  logic                 bit_end;
  logic                 word_avail;
  logic [DATA_BITS-1:0] word;
  logic                 start;
  logic                 tx_d;
  logic                 done_d;

  assign bit_end = (div == CNT_MAX);
  assign start   = (state == S_IDLE) && word_avail;
  assign tx_busy = (state != S_IDLE);

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
  begin : g_bad_depth
    $error("uart_tx_frame: FIFO_DEPTH must be a power of two >= 2");
  end

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic                 empty;
  logic                 full;
  logic                 push;
  logic                 pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = tx_valid && !full;
  assign pop   = start;

  assign tx_ready   = !full;
  assign word_avail = !empty;
  assign word       = mem[rd_ptr[AW-1:0]];

  // FIFO storage; stale entries are harmless once the pointers reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= tx_data;
  end

  // FIFO pointers: a full FIFO blocks the push even when a pop is due
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
`else
  assign tx_ready   = (state == S_IDLE);
  assign word_avail = tx_valid;
  assign word       = tx_data;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state: each bit lasts CLKS_PER_BIT clocks, bit_cnt walks bits
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (start) state_next = S_START;
      S_START: if (bit_end) state_next = S_DATA;
      S_DATA:
        if (bit_end && bit_cnt == DATA_LAST)
          state_next = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (bit_end) state_next = S_STOP;
      S_STOP:
        if (bit_end && bit_cnt == STOP_LAST)
          state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Divider, bit counter, shift register and latched parity bit
  always_ff @(posedge clk) begin
    if (rst) begin
      div     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par     <= 1'b0;
    end else if (state == S_IDLE) begin
      div     <= '0;
      bit_cnt <= '0;
      if (start) begin
        shift <= word;
        par   <= (^word) ^ ODD;
      end
    end else if (bit_end) begin
      div     <= '0;
      bit_cnt <= (state_next != state) ? 4'd0 : bit_cnt + 4'd1;
      if (state == S_DATA) shift <= shift >> 1;
    end else begin
      div <= div + CW'(1);
    end
  end

  // Line level and done strobe for the current state
  always_comb begin
    tx_d   = 1'b1;
    done_d = 1'b0;
    unique case (state)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift[0];
      S_PAR:   tx_d = par;
      S_STOP:  done_d = bit_end && (bit_cnt == STOP_LAST);
      default: tx_d = 1'b1;
    endcase
  end

  // Registered outputs, so tx lags the state by one clock
  always_ff @(posedge clk) begin
    if (rst) begin
      tx      <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      tx      <= tx_d;
      tx_done <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: four line formats, reset mid-frame,
// and the FIFO path when UART_TX_FIFO_EN is defined.
module tb_uart_tx_frame;

  localparam int CPB = 10;
`ifdef UART_TX_FIFO_EN
  localparam int   LAT     = 1;
  localparam logic RDY_MID = 1'b1;
`else
  localparam int   LAT     = 0;
  localparam logic RDY_MID = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] vld = '0;
  logic [3:0] rdy;
  logic [3:0] tx;
  logic [3:0] busy;
  logic [3:0] done;
  logic [3:0][8:0] dat = '0;

  int n_checks = 0;
  int n_err    = 0;
  int done0_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (done[0]) done0_cnt <= done0_cnt + 1;

  uart_tx_frame #(
    .F_CLK(1_000_000), .BAUDRATE(100_000), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u0 (
    .clk(clk), .rst(rst), .tx_data(dat[0][7:0]),
    .tx_valid(vld[0]), .tx_ready(rdy[0]), .tx(tx[0]),
    .tx_busy(busy[0]), .tx_done(done[0])
  );

  uart_tx_frame #(
    .F_CLK(1_000_000), .BAUDRATE(100_000), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) u1 (
    .clk(clk), .rst(rst), .tx_data(dat[1][7:0]),
    .tx_valid(vld[1]), .tx_ready(rdy[1]), .tx(tx[1]),
    .tx_busy(busy[1]), .tx_done(done[1])
  );

  uart_tx_frame #(
    .F_CLK(1_000_000), .BAUDRATE(100_000), .DATA_BITS(8),
    .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u2 (
    .clk(clk), .rst(rst), .tx_data(dat[2][7:0]),
    .tx_valid(vld[2]), .tx_ready(rdy[2]), .tx(tx[2]),
    .tx_busy(busy[2]), .tx_done(done[2])
  );

  uart_tx_frame #(
    .F_CLK(1_000_000), .BAUDRATE(100_000), .DATA_BITS(5),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u3 (
    .clk(clk), .rst(rst), .tx_data(dat[3][4:0]),
    .tx_valid(vld[3]), .tx_ready(rdy[3]), .tx(tx[3]),
    .tx_busy(busy[3]), .tx_done(done[3])
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Present a word on port k and hold valid until it is taken
  task automatic accept(input int k, input logic [8:0] d,
                        output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (rdy[k]) begin
        dat[k] = d;
        vld[k] = 1'b1;
        @(posedge clk);
        #1 vld[k] = 1'b0;
        ok = 1'b1;
      end
    end
    check("accept", 32'(ok), 32'd1);
  endtask

  // exp[j] is the j-th line bit (start first), n bits per frame
  task automatic frame(input int k, input logic [8:0] d,
                       input logic [15:0] exp, input int n);
    logic ok;
    int   dn, dcyc, nb, j, ph;
    accept(k, d, ok);
    if (!ok) return;
    dn = 0;
    dcyc = -1;
    nb = n * CPB;
    for (int c = 0; c <= nb + LAT; c++) begin
      @(negedge clk);
      if (done[k]) begin
        dn++;
        dcyc = c;
      end
      if (c == LAT + 1) begin
        check("busy_mid", 32'(busy[k]), 32'd1);
        check("ready_mid", 32'(rdy[k]), 32'(RDY_MID));
      end
      if (c <= LAT) begin
        check("tx_idle", 32'(tx[k]), 32'd1);
      end else if (c <= nb + LAT) begin
        j  = (c - LAT - 1) / CPB;
        ph = (c - LAT - 1) % CPB;
        if (ph == 0 || ph == 5)
          check($sformatf("tx_bit%0d", j),
                32'(tx[k]), 32'(exp[j]));
      end
    end
    check("done_at", 32'(dcyc), 32'(nb + LAT));
    check("done_cnt", 32'(dn), 32'd1);
    check("busy_end", 32'(busy[k]), 32'd0);
    check("ready_end", 32'(rdy[k]), 32'd1);
  endtask

`ifdef UART_TX_FIFO_EN
  // Decode one 8N1 frame on u0 and report idle cycles before it
  task automatic rx(output logic [7:0] b, output int gap);
    b = '0;
    gap = 0;
    @(negedge clk);
    while (tx[0] === 1'b1 && gap < 3000) begin
      gap++;
      @(negedge clk);
    end
    check("rx_start", 32'(tx[0]), 32'd0);
    repeat (5) @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      repeat (CPB) @(negedge clk);
      b[j] = tx[0];
    end
    repeat (CPB) @(negedge clk);
    check("rx_stop", 32'(tx[0]), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic fifo_test();
    logic [7:0] w [5];
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'hC3;
    w[3] = 8'h5A; w[4] = 8'hF0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check($sformatf("fifo_rdy%0d", i), 32'(rdy[0]), 32'd1);
          dat[0] = {1'b0, w[i]};
          vld[0] = 1'b1;
          @(posedge clk);
          #1;
        end
        vld[0] = 1'b0;
        check("fifo_full", 32'(rdy[0]), 32'd0);
        check("fifo_busy", 32'(busy[0]), 32'd1);
      end
      begin
        logic [7:0] b;
        int gap;
        for (int i = 0; i < 5; i++) begin
          rx(b, gap);
          check($sformatf("fifo_word%0d", i), 32'(b), 32'(w[i]));
          if (i > 0)
            check($sformatf("fifo_gap%0d", i), 32'(gap), 32'd1);
        end
      end
    join
    repeat (3) @(negedge clk);
    check("fifo_drained", 32'(rdy[0]), 32'd1);
    check("fifo_idle", 32'(busy[0]), 32'd0);
  endtask
`endif

  initial begin
    logic ok;
    int   dbase;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_tx%0d", k), 32'(tx[k]), 32'd1);
      check($sformatf("rst_busy%0d", k), 32'(busy[k]), 32'd0);
      check($sformatf("rst_done%0d", k), 32'(done[k]), 32'd0);
      check($sformatf("rst_rdy%0d", k), 32'(rdy[k]), 32'd1);
    end

    frame(0, 9'h0A5, 16'b1_10100101_0, 10);
    frame(0, 9'h05A, 16'b1_01011010_0, 10);
    frame(1, 9'h007, 16'b11_1_00000111_0, 12);
    frame(2, 9'h007, 16'b1_0_00000111_0, 11);
    frame(3, 9'h1FF, 16'b1_11111_0, 7);
    frame(3, 9'h00A, 16'b1_01010_0, 7);

    accept(0, 9'h0A5, ok);
    repeat (35) @(negedge clk);
    check("pre_rst_tx", 32'(tx[0]), 32'd1);
    dbase = done0_cnt;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_tx", 32'(tx[0]), 32'd1);
    check("mid_rst_busy", 32'(busy[0]), 32'd0);
    check("mid_rst_rdy", 32'(rdy[0]), 32'd1);
    check("mid_rst_done", 32'(done[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (120) @(negedge clk);
    check("mid_rst_nodone", 32'(done0_cnt), 32'(dbase));
    check("mid_rst_line", 32'(tx[0]), 32'd1);
    frame(0, 9'h03C, 16'b1_00111100_0, 10);

`ifdef UART_TX_FIFO_EN
    fifo_test();
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
